// File: rtl/uart_to_axi_pkg.sv
// Shared constants and types for the UART-to-AXI-Lite bridge.
// Holds opcodes, status bytes, AXI resp encodings and the FSM state type.
package uart_to_axi_pkg;

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;

    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE     = 3'd0;
    localparam state_t S_GET_ADDR = 3'd1;
    localparam state_t S_GET_DATA = 3'd2;
    localparam state_t S_AXI_WR   = 3'd3;
    localparam state_t S_AXI_B    = 3'd4;
    localparam state_t S_AXI_RD   = 3'd5;
    localparam state_t S_AXI_R    = 3'd6;
    localparam state_t S_TX_RESP  = 3'd7;

    // Any response with resp[1] set is an error.
    function automatic logic [7:0] status_byte(input logic [1:0] resp);
        logic [7:0] s;
        s = ST_ERR;
        unique case (resp)
            RESP_OKAY, RESP_EXOKAY:   s = ST_OK;
            RESP_SLVERR, RESP_DECERR: s = ST_ERR;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/uart_to_axi_master_if.sv
// AXI4-Lite bus bundle between the bridge (master) and a slave.
// Ports: AW, W, B, AR and R channel signals; modports master and slave.
interface uart_to_axi_master_if #(
    parameter int ADDR_W = 6
);
    logic [ADDR_W-1:0] awaddr;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;
    logic [31:0]       wdata;
    logic [3:0]        wstrb;
    logic              wvalid;
    logic              wready;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;
    logic [ADDR_W-1:0] araddr;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;
    logic [31:0]       rdata;
    logic [1:0]        rresp;
    logic              rvalid;
    logic              rready;

    modport master (
        output awaddr, awprot, awvalid, input awready,
        output wdata, wstrb, wvalid, input wready,
        input bresp, bvalid, output bready,
        output araddr, arprot, arvalid, input arready,
        input rdata, rresp, rvalid, output rready
    );

    modport slave (
        input awaddr, awprot, awvalid, output awready,
        input wdata, wstrb, wvalid, output wready,
        output bresp, bvalid, input bready,
        input araddr, arprot, arvalid, output arready,
        output rdata, rresp, rvalid, input rready
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: 2-flop synchronizer, mid-bit sampling, byte output.
// Ports: clk, rst (sync, active-high), rxd in; data, valid pulse, frame_err pulse out.
module uart_rx_byte #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rxd,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] R_IDLE  = 2'd0;
    localparam logic [1:0] R_START = 2'd1;
    localparam logic [1:0] R_DATA  = 2'd2;
    localparam logic [1:0] R_STOP  = 2'd3;

    logic [1:0]    state;
    logic          meta, rx_s, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    assign data = shift;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= R_IDLE;
            meta      <= 1'b1;
            rx_s      <= 1'b1;
            rx_prev   <= 1'b1;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            meta      <= rxd;
            rx_s      <= meta;
            rx_prev   <= rx_s;
            valid     <= 1'b0;
            frame_err <= 1'b0;
            unique case (state)
                // A true falling edge is required, so a line stuck low
                // after a framing error cannot retrigger.
                R_IDLE: begin
                    if (rx_prev && !rx_s) begin
                        cnt   <= '0;
                        state <= R_START;
                    end
                end
                R_START: begin
                    if (cnt == HALF) begin
                        cnt     <= '0;
                        bit_idx <= '0;
                        state   <= rx_s ? R_IDLE : R_DATA;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_DATA: begin
                    if (cnt == FULL) begin
                        cnt   <= '0;
                        shift <= {rx_s, shift[7:1]};
                        if (bit_idx == 3'd7) state <= R_STOP;
                        else bit_idx <= bit_idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                R_STOP: begin
                    if (cnt == FULL) begin
                        cnt       <= '0;
                        state     <= R_IDLE;
                        valid     <= rx_s;
                        frame_err <= !rx_s;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/uart_to_axi_master.sv
// UART command frames to single AXI4-Lite reads/writes, status/data back on UART.
// Ports: m00_axi_aclk, m00_axi_areset (sync, active-high), uart_rxd, uart_txd,
// busy, m00_axi (AXI4-Lite master modport).
// Build option UART_TO_AXI_TIMEOUT_EN: abort partial frames after TIMEOUT_CLKS idle cycles.
module uart_to_axi_master
    import uart_to_axi_pkg::*;
#(
    parameter int C_M00_AXI_DATA_WIDTH = 32,
    parameter int C_M00_AXI_ADDR_WIDTH = 6,
    parameter int CLKS_PER_BIT         = 868,
    parameter int TIMEOUT_CLKS         = 1000000
) (
    input  logic m00_axi_aclk,
    input  logic m00_axi_areset,
    input  logic uart_rxd,
    output logic uart_txd,
    output logic busy,
    uart_to_axi_master_if.master m00_axi
);

    localparam int AW = C_M00_AXI_ADDR_WIDTH;
    localparam int DW = C_M00_AXI_DATA_WIDTH;
    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    state_t        state;
    logic          is_wr;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata_q;
    logic [1:0]    byte_cnt;
    logic          awvalid_q, wvalid_q, bready_q;
    logic          arvalid_q, rready_q;
    logic [39:0]   resp_buf;
    logic [2:0]    tx_left;
    logic [8:0]    tx_sh;
    logic [3:0]    tx_bit;
    logic [CW-1:0] tx_cnt;
    logic          txd_q;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_ferr;
    logic          to_hit;
    logic [7:0]    b_status, r_status;
    logic          aw_ok, w_ok;

    uart_rx_byte #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (m00_axi_aclk),
        .rst      (m00_axi_areset),
        .rxd      (uart_rxd),
        .data     (rx_data),
        .valid    (rx_valid),
        .frame_err(rx_ferr)
    );

`ifdef UART_TO_AXI_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset || rx_valid ||
            !(state inside {S_GET_ADDR, S_GET_DATA}))
            to_cnt <= '0;
        else
            to_cnt <= to_cnt + 1'b1;
    end

    assign to_hit = (to_cnt == TW'(TIMEOUT_CLKS - 1));
`else
    // Partial frames wait forever; the limit has no effect.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CLKS != 0);
    assign to_hit = 1'b0;
`endif

    assign b_status = status_byte(m00_axi.bresp);
    assign r_status = status_byte(m00_axi.rresp);

    // A channel is finished once its valid is gone or handshakes now.
    assign aw_ok = !awvalid_q || m00_axi.awready;
    assign w_ok  = !wvalid_q || m00_axi.wready;

    assign busy     = !(state inside {S_IDLE, S_GET_ADDR, S_GET_DATA});
    assign uart_txd = txd_q;

    assign m00_axi.awaddr  = addr;
    assign m00_axi.awprot  = 3'b000;
    assign m00_axi.awvalid = awvalid_q;
    assign m00_axi.wdata   = wdata_q;
    assign m00_axi.wstrb   = 4'hF;
    assign m00_axi.wvalid  = wvalid_q;
    assign m00_axi.bready  = bready_q;
    assign m00_axi.araddr  = addr;
    assign m00_axi.arprot  = 3'b000;
    assign m00_axi.arvalid = arvalid_q;
    assign m00_axi.rready  = rready_q;

    always_ff @(posedge m00_axi_aclk) begin
        if (m00_axi_areset) begin
            state     <= S_IDLE;
            is_wr     <= 1'b0;
            addr      <= '0;
            wdata_q   <= '0;
            byte_cnt  <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            resp_buf  <= '0;
            tx_left   <= '0;
            tx_sh     <= '1;
            tx_bit    <= '0;
            tx_cnt    <= '0;
            txd_q     <= 1'b1;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (rx_valid && rx_data == OP_WRITE) begin
                        is_wr <= 1'b1;
                        state <= S_GET_ADDR;
                    end else if (rx_valid && rx_data == OP_READ) begin
                        is_wr <= 1'b0;
                        state <= S_GET_ADDR;
                    end
                end
                S_GET_ADDR: begin
                    if (rx_valid) begin
                        addr     <= rx_data[AW-1:0];
                        byte_cnt <= '0;
                        if (is_wr) begin
                            state <= S_GET_DATA;
                        end else begin
                            arvalid_q <= 1'b1;
                            state     <= S_AXI_RD;
                        end
                    end else if (rx_ferr || to_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_GET_DATA: begin
                    if (rx_valid) begin
                        wdata_q  <= {rx_data, wdata_q[DW-1:8]};
                        byte_cnt <= byte_cnt + 1'b1;
                        if (byte_cnt == 2'd3) begin
                            awvalid_q <= 1'b1;
                            wvalid_q  <= 1'b1;
                            state     <= S_AXI_WR;
                        end
                    end else if (rx_ferr || to_hit) begin
                        state <= S_IDLE;
                    end
                end
                S_AXI_WR: begin
                    if (m00_axi.awready) awvalid_q <= 1'b0;
                    if (m00_axi.wready) wvalid_q <= 1'b0;
                    if (aw_ok && w_ok) begin
                        bready_q <= 1'b1;
                        state    <= S_AXI_B;
                    end
                end
                S_AXI_B: begin
                    if (m00_axi.bvalid) begin
                        bready_q <= 1'b0;
                        resp_buf <= {32'h0, b_status};
                        tx_left  <= 3'd1;
                        tx_sh    <= {1'b1, b_status};
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                        txd_q    <= 1'b0;
                        state    <= S_TX_RESP;
                    end
                end
                S_AXI_RD: begin
                    if (m00_axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= S_AXI_R;
                    end
                end
                S_AXI_R: begin
                    if (m00_axi.rvalid) begin
                        rready_q <= 1'b0;
                        resp_buf <= {m00_axi.rdata, r_status};
                        tx_left  <= (r_status == ST_OK) ? 3'd5 : 3'd1;
                        tx_sh    <= {1'b1, r_status};
                        tx_bit   <= '0;
                        tx_cnt   <= '0;
                        txd_q    <= 1'b0;
                        state    <= S_TX_RESP;
                    end
                end
                S_TX_RESP: begin
                    if (tx_cnt != FULL) begin
                        tx_cnt <= tx_cnt + 1'b1;
                    end else begin
                        tx_cnt <= '0;
                        if (tx_bit != 4'd9) begin
                            // tx_sh carries data bits then the stop bit.
                            txd_q  <= tx_sh[0];
                            tx_sh  <= {1'b1, tx_sh[8:1]};
                            tx_bit <= tx_bit + 1'b1;
                        end else if (tx_left == 3'd1) begin
                            state <= S_IDLE;
                        end else begin
                            tx_left  <= tx_left - 1'b1;
                            resp_buf <= {8'h00, resp_buf[39:8]};
                            tx_sh    <= {1'b1, resp_buf[15:8]};
                            tx_bit   <= '0;
                            txd_q    <= 1'b0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_to_axi_master.sv
// Scoreboard bench for uart_to_axi_master: UART frames in, AXI slave model,
// UART responses decoded and compared against queued expectations.
module tb_uart_to_axi_master;
    import uart_to_axi_pkg::*;

    localparam int CPB = 4;
    localparam int TO  = 200;
    localparam int AW  = 6;

    typedef struct {
        logic [AW-1:0] a;
        logic [31:0]   d;
    } wr_t;

    logic clk = 1'b0;
    logic rst;
    logic rxd;
    logic txd;
    logic busy;

    int checks = 0;
    int fails  = 0;

    wr_t           exp_wr[$];
    logic [AW-1:0] exp_rd[$];
    logic [7:0]    exp_tx[$];

    int         aw_delay = 0;
    int         ar_delay = 0;
    logic [1:0] bresp_cfg = 2'b00;
    logic [1:0] rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;
    int         b_hs  = 0;
    int         b_exp = 0;

    uart_to_axi_master_if #(.ADDR_W(AW)) bus ();

    uart_to_axi_master #(
        .C_M00_AXI_DATA_WIDTH(32),
        .C_M00_AXI_ADDR_WIDTH(AW),
        .CLKS_PER_BIT        (CPB),
        .TIMEOUT_CLKS        (TO)
    ) dut (
        .m00_axi_aclk  (clk),
        .m00_axi_areset(rst),
        .uart_rxd      (rxd),
        .uart_txd      (txd),
        .busy          (busy),
        .m00_axi       (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, got, exp);
        end
    endtask

    // ---------------- AXI slave model + AXI scoreboard ----------------
    logic          aw_done = 0, w_done = 0, ar_done = 0, wdrop_chk = 0;
    int            aw_cnt = 0, ar_cnt = 0;
    logic [AW-1:0] aw_first, got_awaddr;
    logic [31:0]   got_wdata;
    logic [3:0]    got_wstrb;
    wr_t           cur_wr;

    initial begin
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
        bus.arready = 0; bus.rvalid = 0; bus.rresp = 0; bus.rdata = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                bus.awready = 0; bus.wready = 0; bus.bvalid = 0;
                bus.arready = 0; bus.rvalid = 0;
                aw_done = 0; w_done = 0; ar_done = 0; wdrop_chk = 0;
                aw_cnt = 0; ar_cnt = 0;
                continue;
            end
            // W: accept immediately
            bus.wready = 0;
            if (bus.wvalid && !w_done) begin
                bus.wready = 1;
                w_done     = 1;
                got_wdata  = bus.wdata;
                got_wstrb  = bus.wstrb;
            end else if (w_done && !aw_done && bus.awvalid && !wdrop_chk) begin
                check("wvalid_drop", bus.wvalid, 0);
                wdrop_chk = 1;
            end
            // AW: optional stall
            bus.awready = 0;
            if (bus.awvalid && !aw_done) begin
                if (aw_cnt == 0) aw_first = bus.awaddr;
                if (aw_cnt >= aw_delay) begin
                    bus.awready = 1;
                    aw_done     = 1;
                    got_awaddr  = bus.awaddr;
                    if (aw_delay > 0) check("awaddr_stable", bus.awaddr, aw_first);
                end else begin
                    aw_cnt++;
                end
            end
            // B
            bus.bvalid = 0;
            if (aw_done && w_done && bus.bready) begin
                bus.bvalid = 1;
                bus.bresp  = bresp_cfg;
                b_hs++;
                if (exp_wr.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL write_unexpected: addr %0h data %0h, required none",
                             got_awaddr, got_wdata);
                end else begin
                    cur_wr = exp_wr.pop_front();
                    check("awaddr", got_awaddr, cur_wr.a);
                    check("wdata", got_wdata, cur_wr.d);
                    check("wstrb", got_wstrb, 4'hF);
                end
                aw_done = 0; w_done = 0; aw_cnt = 0; wdrop_chk = 0;
            end
            // AR: optional stall
            bus.arready = 0;
            if (bus.arvalid && !ar_done) begin
                if (ar_cnt >= ar_delay) begin
                    bus.arready = 1;
                    ar_done     = 1;
                    if (exp_rd.size() == 0) begin
                        checks++; fails++;
                        $display("FAIL read_unexpected: araddr %0h, required none",
                                 bus.araddr);
                    end else begin
                        check("araddr", bus.araddr, exp_rd.pop_front());
                    end
                end else begin
                    ar_cnt++;
                end
            end else if (!bus.arvalid) begin
                ar_cnt = 0;
            end
            // R
            bus.rvalid = 0;
            if (ar_done && bus.rready) begin
                bus.rvalid = 1;
                bus.rdata  = rdata_cfg;
                bus.rresp  = rresp_cfg;
                ar_done    = 0;
                ar_cnt     = 0;
            end
        end
    end

    // ---------------- UART TX monitor ----------------
    logic [7:0] mon_b;
    logic       mon_stop;

    initial begin
        forever begin
            @(negedge clk);
            if (!rst && txd === 1'b0) begin
                repeat (CPB / 2) @(negedge clk);
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge clk);
                    mon_b[i] = txd;
                end
                repeat (CPB) @(negedge clk);
                mon_stop = txd;
                check("tx_stop", mon_stop, 1);
                if (exp_tx.size() == 0) begin
                    checks++; fails++;
                    $display("FAIL tx_unexpected: byte %0h, required none", mon_b);
                end else begin
                    check("tx_byte", mon_b, exp_tx.pop_front());
                end
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b, input logic stop);
        rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        rxd = stop;
        repeat (CPB) @(negedge clk);
        rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    // Bytes are sent from the least significant byte upward.
    task automatic send_frame(input logic [47:0] bytes, input int n);
        for (int i = 0; i < n; i++) send_byte(bytes[8*i +: 8], 1'b1);
    endtask

    task automatic push_wr(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [7:0] st);
        exp_wr.push_back('{a, d});
        exp_tx.push_back(st);
        b_exp++;
    endtask

    task automatic push_rd(input logic [AW-1:0] a, input logic [31:0] d,
                           input logic [1:0] rr, input logic [7:0] st);
        rdata_cfg = d;
        rresp_cfg = rr;
        exp_rd.push_back(a);
        exp_tx.push_back(st);
        if (st == ST_OK)
            for (int i = 0; i < 4; i++) exp_tx.push_back(d[8*i +: 8]);
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (n >= 3000) begin
            fails++;
            $display("FAIL %s_timeout: busy %0b, %0d tx bytes pending, required idle",
                     name, busy, exp_tx.size());
        end
        repeat (20) @(negedge clk);
        check({name, "_wr_pending"}, exp_wr.size(), 0);
        check({name, "_rd_pending"}, exp_rd.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        rst = 1'b1;
        rxd = 1'b1;
        repeat (5) @(negedge clk);
        check("rst_awvalid", bus.awvalid, 0);
        check("rst_wvalid", bus.wvalid, 0);
        check("rst_bready", bus.bready, 0);
        check("rst_arvalid", bus.arvalid, 0);
        check("rst_rready", bus.rready, 0);
        check("rst_awaddr", bus.awaddr, 0);
        check("rst_araddr", bus.araddr, 0);
        check("rst_wdata", bus.wdata, 0);
        check("rst_txd", txd, 1);
        check("rst_busy", busy, 0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // basic write, OKAY
        bresp_cfg = 2'b00;
        push_wr(6'h10, 32'hDEADBEEF, 8'h4B);
        send_frame(48'hDEADBEEF1057, 6);
        wait_done("wr_ok");

        // read, OKAY: status then data LSB first
        push_rd(6'h24, 32'h12345678, 2'b00, 8'h4B);
        send_frame(48'h2452, 2);
        wait_done("rd_ok");

        // read, SLVERR: status only
        push_rd(6'h24, 32'h12345678, 2'b10, 8'h45);
        send_frame(48'h2452, 2);
        wait_done("rd_err");

        // write, DECERR
        bresp_cfg = 2'b11;
        push_wr(6'h3F, 32'h04030201, 8'h45);
        send_frame(48'h040302013F57, 6);
        wait_done("wr_err");

        // AW stalled, W immediate
        bresp_cfg = 2'b00;
        aw_delay  = 10;
        push_wr(6'h2A, 32'h44332211, 8'h4B);
        send_frame(48'h443322112A57, 6);
        check("busy_during_axi", busy, 1);
        wait_done("aw_stall");
        aw_delay = 0;

        // unknown opcode discarded, then read with EXOKAY
        push_rd(6'h08, 32'hA5A55A5A, 2'b01, 8'h4B);
        send_frame(48'h41, 1);
        send_frame(48'h0852, 2);
        wait_done("bad_op");

        // framing error on the address byte drops the frame
        send_byte(8'h52, 1'b1);
        send_byte(8'h08, 1'b0);
        repeat (60) @(negedge clk);
        check("ferr_busy", busy, 0);
        push_rd(6'h08, 32'h0BADF00D, 2'b00, 8'h4B);
        send_frame(48'h0852, 2);
        wait_done("ferr_then_rd");

        // inter-byte idle gap longer than the timeout
        bresp_cfg = 2'b00;
`ifdef UART_TO_AXI_TIMEOUT_EN
        send_frame(48'h1057, 2);
        repeat (TO + 50) @(negedge clk);
        check("timeout_busy", busy, 0);
        push_wr(6'h10, 32'h11223344, 8'h4B);
        send_frame(48'h112233441057, 6);
`else
        send_frame(48'h1057, 2);
        repeat (TO + 50) @(negedge clk);
        check("timeout_busy", busy, 0);
        push_wr(6'h10, 32'h11223344, 8'h4B);
        send_frame(48'h11223344, 4);
`endif
        wait_done("timeout");

        // reset while arvalid is high
        ar_delay = 1000;
        send_frame(48'h2452, 2);
        for (int i = 0; i < 100; i++) begin
            if (bus.arvalid) break;
            @(negedge clk);
        end
        check("arvalid_before_rst", bus.arvalid, 1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_arvalid", bus.arvalid, 0);
        check("rst_mid_txd", txd, 1);
        check("rst_mid_busy", busy, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        ar_delay = 0;
        repeat (60) @(negedge clk);
        check("rst_mid_txd_after", txd, 1);

        // operation resumes after reset
        push_rd(6'h3C, 32'hCAFE0001, 2'b00, 8'h4B);
        send_frame(48'h3C52, 2);
        wait_done("post_rst");

        check("b_handshakes", b_hs, b_exp);
        check("tx_pending", exp_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/uart_to_axi_master.md
UART_TO_AXI_MASTER -- requirements
Module: uart_to_axi_master

Interface
REQ-001 C_M00_AXI_DATA_WIDTH, 32, AXI data width; only 32 supported.
REQ-002 C_M00_AXI_ADDR_WIDTH, 6, AXI address width, at most 8.
REQ-003 CLKS_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200).
REQ-004 TIMEOUT_CLKS, 1000000, maximum idle cycles allowed between bytes of one frame.
REQ-005 m00_axi_aclk  in  1  sole clock.
REQ-006 m00_axi_areset  in  1  reset, synchronous, active-high.
REQ-007 uart_rxd  in  1  serial command input, 8N1, idle high, asynchronous to the clock, 2-flop synchronized.
REQ-008 uart_txd  out  1  serial response output, 8N1, idle high.
REQ-009 busy  out  1  high from acceptance of the final frame byte until the last response stop bit ends.
REQ-010 AW channel: m00_axi_awaddr out ADDR_W; m00_axi_awprot out 3; m00_axi_awvalid out 1; m00_axi_awready in 1.
REQ-011 W channel: m00_axi_wdata out 32; m00_axi_wstrb out 4; m00_axi_wvalid out 1; m00_axi_wready in 1.
REQ-012 B channel: m00_axi_bresp in 2; m00_axi_bvalid in 1; m00_axi_bready out 1.
REQ-013 AR channel: m00_axi_araddr out ADDR_W; m00_axi_arprot out 3; m00_axi_arvalid out 1; m00_axi_arready in 1.
REQ-014 R channel: m00_axi_rdata in 32; m00_axi_rresp in 2; m00_axi_rvalid in 1; m00_axi_rready out 1.

Function
REQ-015 Frame format: opcode byte, address byte, then (write only) 4 data bytes LSB first. Opcodes: 0x57 = write, 0x52 = read. Any other opcode is silently discarded.
REQ-016 Address byte is truncated to its low ADDR_W bits. awprot and arprot are constant 3'b000. wstrb is constant 4'hF.
REQ-017 RX timing: a falling edge starts a byte; the start bit is re-checked at CLKS_PER_BIT/2; 8 data bits are sampled at bit centres, LSB first. If the sampled stop bit is 0, the byte is dropped and the partial frame is aborted.
REQ-018 FSM states: IDLE, GET_ADDR, GET_DATA, AXI_WR, AXI_B, AXI_RD, AXI_R, TX_RESP.
REQ-019 FSM transitions: IDLE→GET_ADDR on a valid opcode. GET_ADDR→AXI_RD (read) or GET_DATA (write). GET_DATA→AXI_WR after 4 bytes. AXI_WR→AXI_B, AXI_B→TX_RESP, AXI_RD→AXI_R, AXI_R→TX_RESP, each on its handshake. TX_RESP→IDLE after the last stop bit.
REQ-020 Write: awvalid and wvalid assert together one cycle after the rx valid pulse of the final data byte. Each deasserts the cycle after its own handshake. bready asserts only after both handshakes and holds until bvalid.
REQ-021 Read: arvalid asserts one cycle after the rx valid pulse of the address byte and deasserts after the arready handshake. rready is high in AXI_R until rvalid.
REQ-022 Addresses and data are held stable while the corresponding valid is high. Only one transaction is outstanding at a time. There is no AXI timeout: a slave that never responds keeps busy high indefinitely.
REQ-023 Status byte = 0x4B if resp[1]==0, otherwise 0x45. A write returns the status byte only. A read returns the status byte, then rdata LSB first only when status is 0x4B.
REQ-024 TX byte = start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT cycles. Bytes go back-to-back with no gap. The start bit begins one cycle after the B or R handshake.
REQ-025 Bytes received outside IDLE, GET_ADDR and GET_DATA are discarded. The rx sub-module keeps running throughout.

Reset
REQ-026 On reset: FSM→IDLE; all valid and ready outputs 0; awaddr, araddr and wdata 0; uart_txd 1; busy 0; partial frame and all bit/byte counters cleared.
REQ-027 Reset mid-transaction: valids drop on the next cycle and no response is sent. Reset mid-TX: uart_txd returns to 1 on the next cycle, truncating the byte.

Configuration
REQ-028 UART_TO_AXI_TIMEOUT_EN defined: an idle-cycle counter runs in GET_ADDR and GET_DATA and restarts on each byte. When it reaches TIMEOUT_CLKS, the partial frame is dropped, FSM→IDLE, and no AXI activity or response occurs.
REQ-029 UART_TO_AXI_TIMEOUT_EN undefined: there is no counter, a partial frame waits indefinitely, and TIMEOUT_CLKS is ignored.

Structure
REQ-030 Package uart_to_axi_pkg holds: opcode constants (0x57, 0x52), status constants (0x4B, 0x45), AXI resp encodings, and the FSM state typedef.
REQ-031 Sub-module uart_rx_byte handles synchronizer, bit timing, data byte, 1-cycle valid pulse and framing-error flag. The TX serializer is inline.

Verification (CLKS_PER_BIT=4, TIMEOUT_CLKS=200)
REQ-032 RX 57 10 EF BE AD DE, bresp 00 → awaddr 0x10, wdata 0xDEADBEEF, wstrb F; TX 4B.
REQ-033 RX 52 24, rdata 0x12345678, rresp 00 → araddr 0x24; TX 4B 78 56 34 12. Same read with rresp 10 → TX 45 only. Write with bresp 11 → TX 45.
REQ-034 awready low 10 cycles, wready immediate → wvalid drops after one cycle, awaddr/awvalid held stable, exactly one B handshake, TX 4B.
REQ-035 RX 41, then 52 08 → no AXI activity for 41; the read of 0x08 completes. Stop bit 0 on the address byte → frame dropped, no AXI activity.
REQ-036 Macro on: RX 57 10, then 200 idle cycles → IDLE, no AXI activity; the following valid frame executes. Macro off: same stimulus, then 4 bytes → write completes.
REQ-037 Reset asserted while arvalid is high → arvalid 0 next cycle, uart_txd stays 1, busy 0.
